// File: rtl/line_fetch_engine.sv
// Line fetcher: on each lineRequest, issues single-word reads on a pipelined memory
// master and writes the in-order returns into a line buffer with stride/repeat stepping.
module line_fetch_engine #(
  parameter int ADDR_WIDTH      = 21,
  parameter int LINE_ADDR_WIDTH = 9,
  parameter int MAX_OUTSTANDING = 8,
  parameter int REPEAT_WIDTH    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      baseAddress,
  input  logic [LINE_ADDR_WIDTH:0]   lineWords,
  input  logic [ADDR_WIDTH-1:0]      lineStride,
  input  logic [REPEAT_WIDTH-1:0]    lineRepeat,
  input  logic                       lineRequest,
  input  logic                       endOfFrame,
  output logic [LINE_ADDR_WIDTH-1:0] lineAddress,
  output logic                       lineWrite,
  output logic [31:0]                lineData,
  output logic                       lineDone,
  output logic                       overrun,
  input  logic                       waitRequest,
  input  logic                       readValid,
  input  logic [31:0]                readData,
  output logic                       read,
  output logic [ADDR_WIDTH-1:0]      address
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = LINE_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0]      stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]      address_q, address_d;
  logic [REPEAT_WIDTH-1:0]    repeat_q, repeat_d;
  logic [REPEAT_WIDTH-1:0]    repeat_cnt_q, repeat_cnt_d;
  logic [CNT_W-1:0]           words_q, words_d;
  logic [CNT_W-1:0]           req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]           rsp_cnt_q, rsp_cnt_d;
  logic [OUT_W-1:0]           outstanding_q, outstanding_d;
  logic                       eof_pending_q, eof_pending_d;
  logic                       read_q, read_d;
  logic                       line_write_q, line_write_d;
  logic                       line_done_q, line_done_d;
  logic                       overrun_q, overrun_d;
  logic [LINE_ADDR_WIDTH-1:0] line_address_q, line_address_d;
  logic [31:0]                line_data_q, line_data_d;

  logic                       accept, busy, rsp, last_rsp;
  logic [ADDR_WIDTH-1:0]      start_base;
  logic [REPEAT_WIDTH-1:0]    start_rep;

  always_comb begin
    accept   = read_q && !waitRequest;
    busy     = (state_q != IDLE);
    rsp      = readValid && busy;
    last_rsp = rsp && ((rsp_cnt_q + CNT_W'(1)) == words_q);

    state_d        = state_q;
    line_base_d    = line_base_q;
    stride_d       = stride_q;
    address_d      = address_q;
    repeat_d       = repeat_q;
    repeat_cnt_d   = repeat_cnt_q;
    words_d        = words_q;
    req_cnt_d      = req_cnt_q;
    rsp_cnt_d      = rsp_cnt_q;
    outstanding_d  = outstanding_q;
    eof_pending_d  = eof_pending_q;
    line_write_d   = 1'b0;
    line_done_d    = 1'b0;
    overrun_d      = 1'b0;
    line_address_d = line_address_q;
    line_data_d    = line_data_q;
    // A same-cycle endOfFrame takes effect before the request is serviced
    start_base     = endOfFrame ? baseAddress : line_base_q;
    start_rep      = endOfFrame ? '0 : repeat_cnt_q;

    if (!busy) begin
      if (endOfFrame) begin
        line_base_d  = baseAddress;
        repeat_cnt_d = '0;
      end
      if (lineRequest) begin
        words_d        = lineWords;
        stride_d       = lineStride;
        repeat_d       = lineRepeat;
        req_cnt_d      = '0;
        rsp_cnt_d      = '0;
        outstanding_d  = '0;
        line_address_d = '0;
        address_d      = start_base;
        if (lineWords == '0) begin
          line_done_d = 1'b1;
          if (start_rep == lineRepeat) begin
            line_base_d  = start_base + lineStride;
            repeat_cnt_d = '0;
          end else begin
            line_base_d  = start_base;
            repeat_cnt_d = start_rep + REPEAT_WIDTH'(1);
          end
        end else begin
          state_d = FETCH;
        end
      end
    end else begin
      if (endOfFrame)  eof_pending_d = 1'b1;
      if (lineRequest) overrun_d     = 1'b1;

      if (accept && !rsp)      outstanding_d = outstanding_q + OUT_W'(1);
      else if (rsp && !accept) outstanding_d = outstanding_q - OUT_W'(1);

      if (accept) begin
        address_d = address_q + ADDR_WIDTH'(1);
        req_cnt_d = req_cnt_q + CNT_W'(1);
        if ((req_cnt_q + CNT_W'(1)) == words_q) state_d = DRAIN;
      end

      if (rsp) begin
        line_write_d   = 1'b1;
        line_data_d    = readData;
        line_address_d = rsp_cnt_q[LINE_ADDR_WIDTH-1:0];
        rsp_cnt_d      = rsp_cnt_q + CNT_W'(1);
      end

      if (last_rsp) begin
        line_done_d = 1'b1;
        state_d     = IDLE;
        if (eof_pending_q || endOfFrame) begin
          line_base_d   = baseAddress;
          repeat_cnt_d  = '0;
          eof_pending_d = 1'b0;
        end else if (repeat_cnt_q == repeat_q) begin
          line_base_d  = line_base_q + stride_q;
          repeat_cnt_d = '0;
        end else begin
          repeat_cnt_d = repeat_cnt_q + REPEAT_WIDTH'(1);
        end
      end
    end

    // Evaluated on next-state counts so a full pipe drops read without a bubble read
    read_d = (state_d == FETCH) && (req_cnt_d < words_d) &&
             (outstanding_d < OUT_W'(MAX_OUTSTANDING));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      line_base_q    <= '0;
      stride_q       <= '0;
      address_q      <= '0;
      repeat_q       <= '0;
      repeat_cnt_q   <= '0;
      words_q        <= '0;
      req_cnt_q      <= '0;
      rsp_cnt_q      <= '0;
      outstanding_q  <= '0;
      eof_pending_q  <= 1'b0;
      read_q         <= 1'b0;
      line_write_q   <= 1'b0;
      line_done_q    <= 1'b0;
      overrun_q      <= 1'b0;
      line_address_q <= '0;
      line_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      line_base_q    <= line_base_d;
      stride_q       <= stride_d;
      address_q      <= address_d;
      repeat_q       <= repeat_d;
      repeat_cnt_q   <= repeat_cnt_d;
      words_q        <= words_d;
      req_cnt_q      <= req_cnt_d;
      rsp_cnt_q      <= rsp_cnt_d;
      outstanding_q  <= outstanding_d;
      eof_pending_q  <= eof_pending_d;
      read_q         <= read_d;
      line_write_q   <= line_write_d;
      line_done_q    <= line_done_d;
      overrun_q      <= overrun_d;
      line_address_q <= line_address_d;
      line_data_q    <= line_data_d;
    end
  end

  assign read        = read_q;
  assign address     = address_q;
  assign lineWrite   = line_write_q;
  assign lineData    = line_data_q;
  assign lineAddress = line_address_q;
  assign lineDone    = line_done_q;
  assign overrun     = overrun_q;

endmodule
